frac_reduce: RTL and testbench

FRAC_REDUCE -- requirements
Module: frac_reduce

---
 rtl/frac_pkg.sv | 18 +
 rtl/div_step.sv | 31 +++
 rtl/frac_reduce.sv | 193 +++++++++++++++++++
 tb/tb_frac_reduce.sv | 235 +++++++++++++++++++++++
 4 files changed

// File: rtl/frac_pkg.sv
// Shared constants and types for the fraction-reduction block.
//   DATA_W : operand / result width
//   CNT_W  : width of the shift-subtract iteration counter
//   state_e: controller states (IDLE, DIV, DONE)
package frac_pkg;

    localparam int unsigned DATA_W  = 32;
    localparam int unsigned REM_W   = DATA_W + 1;
    localparam int unsigned CNT_W   = 5;
    localparam int unsigned CNT_MAX = DATA_W - 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        DIV  = 2'd1,
        DONE = 2'd2
    } state_e;

endpackage : frac_pkg

// File: rtl/div_step.sv
// One combinational restoring-division step.
// Ports:
//   rem_i  : partial remainder before this step (always < div_i)
//   bit_i  : next dividend bit, MSB first
//   div_i  : divisor
//   rem_o  : partial remainder after this step
//   q_o    : quotient bit produced by this step
module div_step
    import frac_pkg::*;
(
    input  logic [REM_W-1:0]  rem_i,
    input  logic              bit_i,
    input  logic [DATA_W-1:0] div_i,
    output logic [REM_W-1:0]  rem_o,
    output logic              q_o
);

    // One spare bit so the shift never overflows the compare.
    logic [REM_W:0] shifted;
    logic [REM_W:0] divisor;
    logic [REM_W:0] diff;

    always_comb begin
        shifted = {rem_i, bit_i};
        divisor = (REM_W + 1)'(div_i);
        diff    = shifted - divisor;
        q_o     = (shifted >= divisor);
        rem_o   = q_o ? REM_W'(diff) : REM_W'(shifted);
    end

endmodule : div_step

// File: rtl/frac_reduce.sv
// Reduces a fraction num/den by a precomputed gcd g using two parallel
// 32-step restoring dividers. Result appears 33 cycles after acceptance;
// g==0 bypasses division and flags div_err.
// Ports:
//   clk, rst            : clock, asynchronous active-high reset
//   in_valid/in_ready   : operand handshake (num, den, g)
//   out_valid/out_ready : result handshake (q_num, q_den, div_err, rem_err)
// Build option: FRAC_REDUCE_REMCHECK_EN enables rem_err (nonzero final
// remainder); otherwise rem_err is tied low.
module frac_reduce
    import frac_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] num,
    input  logic [DATA_W-1:0] den,
    input  logic [DATA_W-1:0] g,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] q_num,
    output logic [DATA_W-1:0] q_den,
    output logic              div_err,
    output logic              rem_err
);

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               last_q, last_d;
    logic [DATA_W-1:0]  num_q, num_d;
    logic [DATA_W-1:0]  den_q, den_d;
    logic [DATA_W-1:0]  g_q, g_d;
    logic [REM_W-1:0]   rn_q, rn_d;
    logic [REM_W-1:0]   rd_q, rd_d;
    logic [DATA_W-1:0]  q_num_q, q_num_d;
    logic [DATA_W-1:0]  q_den_q, q_den_d;
    logic               div_err_q, div_err_d;
    logic               in_ready_q, in_ready_d;
    logic               out_valid_q, out_valid_d;
`ifdef FRAC_REDUCE_REMCHECK_EN
    logic               rem_err_q, rem_err_d;
`endif

    logic [REM_W-1:0]   rn_step;
    logic [REM_W-1:0]   rd_step;
    logic               qn_bit;
    logic               qd_bit;

    // Dividend registers shift out MSB-first while quotient bits shift in.
    div_step u_step_num (
        .rem_i (rn_q),
        .bit_i (num_q[DATA_W-1]),
        .div_i (g_q),
        .rem_o (rn_step),
        .q_o   (qn_bit)
    );

    div_step u_step_den (
        .rem_i (rd_q),
        .bit_i (den_q[DATA_W-1]),
        .div_i (g_q),
        .rem_o (rd_step),
        .q_o   (qd_bit)
    );

    // State and datapath registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            last_q      <= 1'b0;
            num_q       <= '0;
            den_q       <= '0;
            g_q         <= '0;
            rn_q        <= '0;
            rd_q        <= '0;
            q_num_q     <= '0;
            q_den_q     <= '0;
            div_err_q   <= 1'b0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
`ifdef FRAC_REDUCE_REMCHECK_EN
            rem_err_q   <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            last_q      <= last_d;
            num_q       <= num_d;
            den_q       <= den_d;
            g_q         <= g_d;
            rn_q        <= rn_d;
            rd_q        <= rd_d;
            q_num_q     <= q_num_d;
            q_den_q     <= q_den_d;
            div_err_q   <= div_err_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
`ifdef FRAC_REDUCE_REMCHECK_EN
            rem_err_q   <= rem_err_d;
`endif
        end
    end

    // Next-state and datapath control.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        last_d      = last_q;
        num_d       = num_q;
        den_d       = den_q;
        g_d         = g_q;
        rn_d        = rn_q;
        rd_d        = rd_q;
        q_num_d     = q_num_q;
        q_den_d     = q_den_q;
        div_err_d   = div_err_q;
        in_ready_d  = in_ready_q;
        out_valid_d = out_valid_q;
`ifdef FRAC_REDUCE_REMCHECK_EN
        rem_err_d   = rem_err_q;
`endif

        case (state_q)
            IDLE: begin
                if (in_valid && in_ready_q) begin
                    num_d      = num;
                    den_d      = den;
                    g_d        = g;
                    rn_d       = '0;
                    rd_d       = '0;
                    state_d    = DIV;
                    in_ready_d = 1'b0;
                    // g==0 skips the steps: one DIV cycle, then DONE.
                    if (g != '0) begin
                        cnt_d  = CNT_W'(CNT_MAX);
                        last_d = 1'b0;
                    end else begin
                        cnt_d  = '0;
                        last_d = 1'b1;
                    end
                end
            end

            DIV: begin
                if (last_q) begin
                    state_d     = DONE;
                    out_valid_d = 1'b1;
                    q_num_d     = num_q;
                    q_den_d     = den_q;
                    div_err_d   = (g_q == '0);
`ifdef FRAC_REDUCE_REMCHECK_EN
                    rem_err_d   = (rn_q != '0) || (rd_q != '0);
`endif
                end else begin
                    num_d  = {num_q[DATA_W-2:0], qn_bit};
                    den_d  = {den_q[DATA_W-2:0], qd_bit};
                    rn_d   = rn_step;
                    rd_d   = rd_step;
                    cnt_d  = cnt_q - CNT_W'(1);
                    last_d = (cnt_q == '0);
                end
            end

            DONE: begin
                if (out_ready) begin
                    state_d     = IDLE;
                    out_valid_d = 1'b0;
                    in_ready_d  = 1'b1;
                end
            end

            default: begin
                state_d     = IDLE;
                out_valid_d = 1'b0;
                in_ready_d  = 1'b1;
            end
        endcase
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign q_num     = q_num_q;
    assign q_den     = q_den_q;
    assign div_err   = div_err_q;
`ifdef FRAC_REDUCE_REMCHECK_EN
    assign rem_err   = rem_err_q;
`else
    assign rem_err   = 1'b0;
`endif

endmodule : frac_reduce

// File: tb/tb_frac_reduce.sv
// Directed self-checking bench for frac_reduce.
module tb_frac_reduce;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] num;
    logic [31:0] den;
    logic [31:0] g;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] q_num;
    logic [31:0] q_den;
    logic        div_err;
    logic        rem_err;

    int checks = 0;
    int errors = 0;

`ifdef FRAC_REDUCE_REMCHECK_EN
    localparam logic REMCHK = 1'b1;
`else
    localparam logic REMCHK = 1'b0;
`endif

    frac_reduce dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .num       (num),
        .den       (den),
        .g         (g),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .q_num     (q_num),
        .q_den     (q_den),
        .div_err   (div_err),
        .rem_err   (rem_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Present one operand set, pass the accepting edge, then count edges
    // until out_valid (bounded). Returns in_ready seen before the edge.
    task automatic send_and_wait(input logic [31:0] n, input logic [31:0] d,
                                 input logic [31:0] gg, output logic rdy,
                                 output int lat);
        num = n; den = d; g = gg; in_valid = 1'b1;
        rdy = in_ready;
        @(posedge clk); #1;
        in_valid = 1'b0;
        lat = 0;
        while (!out_valid && lat < 100) begin
            @(posedge clk); #1;
            lat++;
        end
    endtask

    task automatic consume();
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
        num = '0; den = '0; g = '0;
        #12;
        checks++;
        if ({in_ready, out_valid, div_err, rem_err} !== 4'b1000) begin
            errors++;
            $display("FAIL reset_flags: got %b want 1000", {in_ready, out_valid, div_err, rem_err});
        end
        checks++;
        if (q_num !== 32'd0 || q_den !== 32'd0) begin
            errors++;
            $display("FAIL reset_data: got %0d/%0d want 0/0", q_num, q_den);
        end
        @(negedge clk); rst = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_basic();
        logic rdy; int lat;
        send_and_wait(32'd12, 32'd18, 32'd6, rdy, lat);
        checks++;
        if (rdy !== 1'b1) begin errors++; $display("FAIL basic_in_ready: got %b want 1", rdy); end
        checks++;
        if (lat != 33) begin errors++; $display("FAIL basic_latency: got %0d want 33", lat); end
        checks++;
        if (q_num !== 32'd2 || q_den !== 32'd3 || div_err !== 1'b0 || rem_err !== 1'b0) begin
            errors++;
            $display("FAIL basic_result: got %0d/%0d de=%b re=%b want 2/3 de=0 re=0", q_num, q_den, div_err, rem_err);
        end
        checks++;
        if (in_ready !== 1'b0) begin errors++; $display("FAIL basic_ready_in_done: got %b want 0", in_ready); end
        consume();
        checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            errors++;
            $display("FAIL basic_release: got rdy=%b ov=%b want 1/0", in_ready, out_valid);
        end
    endtask

    task automatic test_max();
        logic rdy; int lat;
        send_and_wait(32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, rdy, lat);
        checks++;
        if (lat != 33 || q_num !== 32'd1 || q_den !== 32'd1) begin
            errors++;
            $display("FAIL max_result: got lat=%0d %0d/%0d want lat=33 1/1", lat, q_num, q_den);
        end
        consume();
    endtask

    task automatic test_div_zero();
        logic rdy; int lat;
        send_and_wait(32'd7, 32'd9, 32'd0, rdy, lat);
        checks++;
        if (lat != 1) begin errors++; $display("FAIL dz_latency: got %0d want 1", lat); end
        checks++;
        if (q_num !== 32'd7 || q_den !== 32'd9 || div_err !== 1'b1 || rem_err !== 1'b0) begin
            errors++;
            $display("FAIL dz_result: got %0d/%0d de=%b re=%b want 7/9 de=1 re=0", q_num, q_den, div_err, rem_err);
        end
        consume();
        checks++;
        if (out_valid !== 1'b0) begin errors++; $display("FAIL dz_release: got ov=%b want 0", out_valid); end
    endtask

    // Zero numerator and unit gcd boundaries.
    task automatic test_edges();
        logic rdy; int lat;
        send_and_wait(32'd0, 32'd40, 32'd8, rdy, lat);
        checks++;
        if (lat != 33 || q_num !== 32'd0 || q_den !== 32'd5) begin
            errors++;
            $display("FAIL zero_num: got lat=%0d %0d/%0d want lat=33 0/5", lat, q_num, q_den);
        end
        consume();
        send_and_wait(32'hDEAD_BEEF, 32'h1234_5678, 32'd1, rdy, lat);
        checks++;
        if (q_num !== 32'hDEAD_BEEF || q_den !== 32'h1234_5678 || div_err !== 1'b0) begin
            errors++;
            $display("FAIL g_one: got %h/%h de=%b want deadbeef/12345678 de=0", q_num, q_den, div_err);
        end
        consume();
    endtask

    // Hold out_ready low with new input offered; result must not change.
    task automatic test_back_pressure();
        logic rdy; int lat; int bad;
        send_and_wait(32'd12, 32'd18, 32'd6, rdy, lat);
        num = 32'd100; den = 32'd50; g = 32'd10; in_valid = 1'b1;
        bad = 0;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #1;
            if (out_valid !== 1'b1 || in_ready !== 1'b0 || q_num !== 32'd2 || q_den !== 32'd3) bad++;
        end
        checks++;
        if (bad != 0) begin errors++; $display("FAIL bp_hold: got %0d bad cycles want 0", bad); end
        consume();
        in_valid = 1'b0;
        checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            errors++;
            $display("FAIL bp_release: got rdy=%b ov=%b want 1/0", in_ready, out_valid);
        end
        @(posedge clk); #1;
        checks++;
        if (in_ready !== 1'b1) begin errors++; $display("FAIL bp_no_accept: got rdy=%b want 1", in_ready); end
    endtask

    task automatic test_reset_mid();
        logic rdy; int lat; int seen;
        num = 32'd12; den = 32'd18; g = 32'd6; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (15) @(posedge clk);
        #2 rst = 1'b1;
        #1;
        checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0 || q_num !== 32'd0) begin
            errors++;
            $display("FAIL mid_reset_now: got rdy=%b ov=%b qn=%0d want 1/0/0", in_ready, out_valid, q_num);
        end
        @(negedge clk); rst = 1'b0;
        send_and_wait(32'd35, 32'd21, 32'd7, rdy, lat);
        checks++;
        if (rdy !== 1'b1 || lat != 33 || q_num !== 32'd5 || q_den !== 32'd3) begin
            errors++;
            $display("FAIL mid_reset_result: got rdy=%b lat=%0d %0d/%0d want 1 33 5/3", rdy, lat, q_num, q_den);
        end
        consume();
        // Reset in DONE drops the pending result.
        send_and_wait(32'd4, 32'd6, 32'd2, rdy, lat);
        rst = 1'b1; #1;
        seen = out_valid;
        @(negedge clk); rst = 1'b0;
        checks++;
        if (seen !== 0 || q_num !== 32'd0) begin
            errors++;
            $display("FAIL done_reset: got ov=%0d qn=%0d want 0/0", seen, q_num);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_remcheck();
        logic rdy; int lat;
        send_and_wait(32'd12, 32'd18, 32'd5, rdy, lat);
        checks++;
        if (q_num !== 32'd2 || q_den !== 32'd3 || rem_err !== REMCHK) begin
            errors++;
            $display("FAIL remcheck: got %0d/%0d re=%b want 2/3 re=%b", q_num, q_den, rem_err, REMCHK);
        end
        consume();
    endtask

    initial begin
        test_reset();
        test_basic();
        test_max();
        test_div_zero();
        test_edges();
        test_back_pressure();
        test_reset_mid();
        test_remcheck();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule : tb_frac_reduce
